// File: rtl/synth_pkg.sv
// synth_pkg: shared envelope phase encoding and level constants
package synth_pkg;

   localparam int ENV_LVL_W  = 16;
   localparam int ENV_RATE_W = 16;
   localparam logic [ENV_LVL_W-1:0] LVL_MAX = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_phase_t;

endpackage

// File: rtl/env_sat_step.sv
// env_sat_step: saturating add toward a ceiling or subtract toward a floor, with at-limit flag
module env_sat_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_lim,
   input  logic         i_sub,
   output logic [W-1:0] o_y,
   output logic         o_at_lim
);

   logic [W:0] w_sum;
   logic [W:0] w_floor;

   assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
   assign w_floor  = {1'b0, i_lim} + {1'b0, i_b};
   assign o_at_lim = i_sub ? ({1'b0, i_a} <= w_floor) : (w_sum >= {1'b0, i_lim});
   assign o_y      = o_at_lim ? i_lim : (i_sub ? i_a - i_b : w_sum[W-1:0]);

endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice linear ADSR envelope; define ADSR_RETRIG_EN for hard retrigger on every gate rise
module adsr_envelope
   import synth_pkg::*;
#(
   parameter int LVL_W  = ENV_LVL_W,
   parameter int RATE_W = ENV_RATE_W
) (
   input  logic              clk48m,
   input  logic              rst_n,
   input  logic              sample_tick,
   input  logic              gate,
   input  logic [RATE_W-1:0] attack_rate,
   input  logic [RATE_W-1:0] decay_rate,
   input  logic [LVL_W-1:0]  sustain_level,
   input  logic [RATE_W-1:0] release_rate,
   output logic [LVL_W-1:0]  level,
   output logic [2:0]        phase,
   output logic              busy
);

   localparam int SW = (LVL_W > RATE_W) ? LVL_W : RATE_W;
   localparam logic [SW-1:0] MAX = SW'({LVL_W{1'b1}});

   env_phase_t       r_phase;
   env_phase_t       w_phase_nxt;
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_nxt;
   logic             r_gate_q;
   logic             w_rise;
   logic             w_restart;
   logic             w_ramp_up;
   logic             w_sub;
   logic             w_at_lim;
   logic [SW-1:0]    w_base;
   logic [SW-1:0]    w_a;
   logic [SW-1:0]    w_b;
   logic [SW-1:0]    w_lim;
   logic [SW-1:0]    w_y;

   assign w_rise = gate && !r_gate_q;

`ifdef ADSR_RETRIG_EN
   assign w_restart = w_rise;
   assign w_base    = '0;
`else
   assign w_restart = w_rise && (r_phase == IDLE || r_phase == RELEASE);
   assign w_base    = SW'(r_level);
`endif

   // One shared ramp unit: attack climbs to MAX, decay falls to sustain, release falls to zero
   assign w_ramp_up = w_restart || r_phase == ATTACK;
   assign w_sub     = !w_ramp_up;
   assign w_a       = w_restart ? w_base : SW'(r_level);
   assign w_b       = w_ramp_up ? SW'(attack_rate) :
                      (r_phase == DECAY ? SW'(decay_rate) : SW'(release_rate));
   assign w_lim     = w_ramp_up ? MAX : (r_phase == DECAY ? SW'(sustain_level) : '0);

   env_sat_step #(.W(SW)) u_step (
      .i_a      (w_a),
      .i_b      (w_b),
      .i_lim    (w_lim),
      .i_sub    (w_sub),
      .o_y      (w_y),
      .o_at_lim (w_at_lim)
   );

   // Next phase and level; a falling gate wins over any level-reached condition
   always_comb begin
      w_phase_nxt = r_phase;
      w_level_nxt = r_level;
      if (w_restart) begin
         w_phase_nxt = ATTACK;
         w_level_nxt = w_y[LVL_W-1:0];
      end else begin
         case (r_phase)
            IDLE: w_level_nxt = '0;
            ATTACK, DECAY: begin
               if (!gate) begin
                  w_phase_nxt = RELEASE;
               end else begin
                  w_level_nxt = w_y[LVL_W-1:0];
                  if (w_at_lim) w_phase_nxt = (r_phase == ATTACK) ? DECAY : SUSTAIN;
               end
            end
            SUSTAIN: begin
               if (!gate) w_phase_nxt = RELEASE;
               else w_level_nxt = sustain_level;
            end
            RELEASE: begin
               w_level_nxt = w_y[LVL_W-1:0];
               if (w_at_lim) w_phase_nxt = IDLE;
            end
            default: begin
               w_phase_nxt = IDLE;
               w_level_nxt = '0;
            end
         endcase
      end
   end

   // State, level and gate history advance only on sample ticks
   always_ff @(posedge clk48m or negedge rst_n) begin
      if (!rst_n) begin
         r_phase  <= IDLE;
         r_level  <= '0;
         r_gate_q <= 1'b0;
      end else if (sample_tick) begin
         r_phase  <= w_phase_nxt;
         r_level  <= w_level_nxt;
         r_gate_q <= gate;
      end
   end

   assign level = r_level;
   assign phase = r_phase;
   assign busy  = r_phase != IDLE;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: table-driven and scoreboard checks of the ADSR envelope
module tb_adsr_envelope;
   import synth_pkg::*;

   logic        clk48m = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_tick = 1'b0;
   logic        gate = 1'b0;
   logic [15:0] attack_rate = '0;
   logic [15:0] decay_rate = '0;
   logic [15:0] sustain_level = '0;
   logic [15:0] release_rate = '0;
   logic [15:0] level;
   logic [2:0]  phase;
   logic        busy;

   typedef struct {
      logic        g;
      logic [15:0] ar;
      logic [15:0] dr;
      logic [15:0] sl;
      logic [15:0] rr;
      logic [15:0] lvl;
      env_phase_t  ph;
   } vec_t;

   typedef struct {
      logic [15:0] lvl;
      env_phase_t  ph;
   } exp_t;

   exp_t sb[$];
   vec_t v[12];
   int   errors = 0;
   int   checks = 0;

   always #5 clk48m = ~clk48m;

   adsr_envelope dut (
      .clk48m        (clk48m),
      .rst_n         (rst_n),
      .sample_tick   (sample_tick),
      .gate          (gate),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .level         (level),
      .phase         (phase),
      .busy          (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic compare_out(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         check({name, ".level"}, 32'(level), 32'(e.lvl));
         check({name, ".phase"}, 32'(phase), 32'(e.ph));
         check({name, ".busy"}, 32'(busy), 32'(e.ph != IDLE));
      end
   endtask

   task automatic push(input logic [15:0] lvl, input env_phase_t ph);
      exp_t e;
      e.lvl = lvl;
      e.ph  = ph;
      sb.push_back(e);
   endtask

   task automatic tick(input string name, input logic [15:0] lvl, input env_phase_t ph);
      @(negedge clk48m);
      sample_tick = 1'b1;
      push(lvl, ph);
      @(negedge clk48m);
      sample_tick = 1'b0;
      compare_out(name);
   endtask

   task automatic hold(input string name, input logic [15:0] lvl, input env_phase_t ph);
      repeat (3) @(negedge clk48m);
      push(lvl, ph);
      compare_out(name);
   endtask

   initial begin
      v[0]  = '{1'b1, 16'h4000, 16'h2000, 16'h8000, 16'h3000, 16'h4000, ATTACK};
      v[1]  = '{1'b1, 16'h4000, 16'h2000, 16'h8000, 16'h3000, 16'h8000, ATTACK};
      v[2]  = '{1'b1, 16'h4000, 16'h2000, 16'h8000, 16'h3000, 16'hC000, ATTACK};
      v[3]  = '{1'b1, 16'h4000, 16'h2000, 16'h8000, 16'h3000, 16'hFFFF, DECAY};
      v[4]  = '{1'b1, 16'h4000, 16'h2000, 16'h8000, 16'h3000, 16'hDFFF, DECAY};
      v[5]  = '{1'b1, 16'h4000, 16'h2000, 16'h8000, 16'h3000, 16'hBFFF, DECAY};
      v[6]  = '{1'b1, 16'h4000, 16'h2000, 16'h8000, 16'h3000, 16'h9FFF, DECAY};
      v[7]  = '{1'b1, 16'h4000, 16'h2000, 16'h8000, 16'h3000, 16'h8000, SUSTAIN};
      v[8]  = '{1'b1, 16'h4000, 16'h2000, 16'h6000, 16'h3000, 16'h6000, SUSTAIN};
      v[9]  = '{1'b0, 16'h4000, 16'h2000, 16'h6000, 16'h3000, 16'h6000, RELEASE};
      v[10] = '{1'b0, 16'h4000, 16'h2000, 16'h6000, 16'h3000, 16'h3000, RELEASE};
      v[11] = '{1'b0, 16'h4000, 16'h2000, 16'h6000, 16'h3000, 16'h0000, IDLE};

      repeat (2) @(negedge clk48m);
      push(16'h0, IDLE);
      compare_out("reset");
      rst_n = 1'b1;
      hold("idle_hold", 16'h0, IDLE);

      for (int i = 0; i < 12; i++) begin
         gate          = v[i].g;
         attack_rate   = v[i].ar;
         decay_rate    = v[i].dr;
         sustain_level = v[i].sl;
         release_rate  = v[i].rr;
         tick($sformatf("vec%0d", i), v[i].lvl, v[i].ph);
      end

      @(negedge clk48m);
      gate = 1'b1;
      @(negedge clk48m);
      gate = 1'b0;
      tick("pulse_ignored", 16'h0, IDLE);

      gate = 1'b1;
      attack_rate = 16'h4000;
      tick("early_a1", 16'h4000, ATTACK);
      tick("early_a2", 16'h8000, ATTACK);
      gate = 1'b0;
      tick("early_rel", 16'h8000, RELEASE);
      hold("rel_hold", 16'h8000, RELEASE);
      release_rate = 16'h5000;
      tick("rel_step", 16'h3000, RELEASE);

      gate = 1'b1;
      attack_rate = 16'h1000;
`ifdef ADSR_RETRIG_EN
      tick("retrig", 16'h1000, ATTACK);
      tick("retrig_a2", 16'h2000, ATTACK);
`else
      tick("retrig", 16'h4000, ATTACK);
      tick("retrig_a2", 16'h5000, ATTACK);
`endif

      @(negedge clk48m);
      #2 rst_n = 1'b0;
      #1;
      push(16'h0, IDLE);
      compare_out("async_reset");
      @(negedge clk48m);
      rst_n = 1'b1;
      attack_rate = 16'h4000;
      tick("post_reset_rise", 16'h4000, ATTACK);
      attack_rate = 16'h0000;
      tick("zero_rate_hold", 16'h4000, ATTACK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
